// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner: per-pin pad synchroniser, stable-count debouncer and rise/fall strobes.
// Define GPIO_EDGE_IRQ_EN to add the edge-interrupt pending register and the combined irq line.
module gpio_input_conditioner #(
    parameter int WIDTH           = 14,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             MainClk,
    input  logic             ResetN,
    input  logic [WIDTH-1:0] pad_in,
    input  logic [WIDTH-1:0] filter_en,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    input  logic [WIDTH-1:0] rise_irq_en,
    input  logic [WIDTH-1:0] fall_irq_en,
    input  logic [WIDTH-1:0] irq_clear,
    output logic [WIDTH-1:0] irq_pending,
    output logic             irq
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_chain [SYNC_STAGES];
    logic [WIDTH-1:0] sync_lvl;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_next;
    logic [WIDTH-1:0] rise_next;
    logic [WIDTH-1:0] fall_next;
    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];
    logic [CNT_W:0]   step_pin;

    // Returns {next_stable, next_cnt}; any sample matching the held level restarts the count.
    function automatic logic [CNT_W:0] debounce_step(
        input logic             filt,
        input logic             smp,
        input logic             cur,
        input logic [CNT_W-1:0] cnt_cur
    );
        if (!filt)
            return {smp, CNT_W'(0)};
        if (smp == cur)
            return {cur, CNT_W'(0)};
        if (cnt_cur == CNT_LAST)
            return {smp, CNT_W'(0)};
        return {cur, cnt_cur + CNT_W'(1)};
    endfunction

    // Synchroniser stage: the only logic that ever sees pad_in.
    always_ff @(posedge MainClk or negedge ResetN) begin
        if (!ResetN) begin
            for (int s = 0; s < SYNC_STAGES; s++)
                sync_chain[s] <= '0;
        end else begin
            sync_chain[0] <= pad_in;
            for (int s = 1; s < SYNC_STAGES; s++)
                sync_chain[s] <= sync_chain[s-1];
        end
    end

    assign sync_lvl = sync_chain[SYNC_STAGES-1];

    always_comb begin
        stable_next = stable;
        step_pin    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            step_pin       = debounce_step(filter_en[i], sync_lvl[i], stable[i], cnt[i]);
            stable_next[i] = step_pin[CNT_W];
            cnt_next[i]    = step_pin[CNT_W-1:0];
        end
    end

    assign rise_next = ~stable & stable_next;
    assign fall_next = stable & ~stable_next;

    // Debounce/strobe stage: strobes register on the same edge as the new level.
    always_ff @(posedge MainClk or negedge ResetN) begin
        if (!ResetN) begin
            stable     <= '0;
            rise_pulse <= '0;
            fall_pulse <= '0;
            for (int i = 0; i < WIDTH; i++)
                cnt[i] <= '0;
        end else begin
            stable     <= stable_next;
            rise_pulse <= rise_next;
            fall_pulse <= fall_next;
            for (int i = 0; i < WIDTH; i++)
                cnt[i] <= cnt_next[i];
        end
    end

    assign clean_out = stable;

`ifdef GPIO_EDGE_IRQ_EN
    logic [WIDTH-1:0] pend_set;

    assign pend_set = (rise_next & rise_irq_en) | (fall_next & fall_irq_en);

    // Pending stage: a new event in the clearing cycle keeps the bit set.
    always_ff @(posedge MainClk or negedge ResetN) begin
        if (!ResetN) begin
            irq_pending <= '0;
            irq         <= 1'b0;
        end else begin
            irq_pending <= pend_set | (irq_pending & ~irq_clear);
            irq         <= |irq_pending;
        end
    end
`else
    logic unused_irq_inputs;

    assign unused_irq_inputs = ^{rise_irq_en, fall_irq_en, irq_clear};
    assign irq_pending       = '0;
    assign irq               = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench for gpio_input_conditioner: vector table plus hand-written multi-cycle sequences.
module tb_gpio_input_conditioner;
    localparam int W = 14;
    localparam logic [W-1:0] ALL = 14'h3FFF;
    localparam logic [W-1:0] BP7 = 14'h3F7F;

`ifdef GPIO_EDGE_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif
    localparam logic [W-1:0] P5 = IRQ_ON ? 14'h0020 : 14'h0000;
    localparam logic [W-1:0] I1 = {13'b0, IRQ_ON};

    logic         MainClk;
    logic         ResetN;
    logic [W-1:0] pad_in;
    logic [W-1:0] filter_en;
    logic [W-1:0] clean_out;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;
    logic [W-1:0] rise_irq_en;
    logic [W-1:0] fall_irq_en;
    logic [W-1:0] irq_clear;
    logic [W-1:0] irq_pending;
    logic         irq;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [W-1:0] pad;
        logic [W-1:0] filt;
        logic [W-1:0] clean;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } vec_t;

    vec_t vecs[$];

    gpio_input_conditioner #(
        .WIDTH(W),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .MainClk(MainClk),
        .ResetN(ResetN),
        .pad_in(pad_in),
        .filter_en(filter_en),
        .clean_out(clean_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .rise_irq_en(rise_irq_en),
        .fall_irq_en(fall_irq_en),
        .irq_clear(irq_clear),
        .irq_pending(irq_pending),
        .irq(irq)
    );

    initial MainClk = 1'b0;
    always #5 MainClk = ~MainClk;

    task automatic step();
        @(posedge MainClk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input int n, input logic [W-1:0] pad, input logic [W-1:0] filt,
                                input logic [W-1:0] clean, input logic [W-1:0] rise,
                                input logic [W-1:0] fall);
        vec_t v;
        v.pad   = pad;
        v.filt  = filt;
        v.clean = clean;
        v.rise  = rise;
        v.fall  = fall;
        for (int k = 0; k < n; k++)
            vecs.push_back(v);
    endfunction

    initial begin
        // Pin 3: 3-cycle glitch rejected, then a 4-cycle pulse accepted and released.
        add(3, 14'h0008, ALL, 14'h0000, 14'h0000, 14'h0000);
        add(5, 14'h0000, ALL, 14'h0000, 14'h0000, 14'h0000);
        add(4, 14'h0008, ALL, 14'h0000, 14'h0000, 14'h0000);
        add(1, 14'h0000, ALL, 14'h0000, 14'h0000, 14'h0000);
        add(1, 14'h0000, ALL, 14'h0008, 14'h0008, 14'h0000);
        add(3, 14'h0000, ALL, 14'h0008, 14'h0000, 14'h0000);
        add(1, 14'h0000, ALL, 14'h0000, 14'h0000, 14'h0008);
        add(1, 14'h0000, ALL, 14'h0000, 14'h0000, 14'h0000);
        // Pin 0 bounce 1,0,1,1,0,1,1,1,1,... then settle low.
        add(1, 14'h0001, ALL, 14'h0000, 14'h0000, 14'h0000);
        add(1, 14'h0000, ALL, 14'h0000, 14'h0000, 14'h0000);
        add(2, 14'h0001, ALL, 14'h0000, 14'h0000, 14'h0000);
        add(1, 14'h0000, ALL, 14'h0000, 14'h0000, 14'h0000);
        add(5, 14'h0001, ALL, 14'h0000, 14'h0000, 14'h0000);
        add(1, 14'h0001, ALL, 14'h0001, 14'h0001, 14'h0000);
        add(2, 14'h0001, ALL, 14'h0001, 14'h0000, 14'h0000);
        add(5, 14'h0000, ALL, 14'h0001, 14'h0000, 14'h0000);
        add(1, 14'h0000, ALL, 14'h0000, 14'h0000, 14'h0001);
        add(1, 14'h0000, ALL, 14'h0000, 14'h0000, 14'h0000);
        // Pin 7 in bypass: one-cycle pad pulse passes straight through.
        add(1, 14'h0080, BP7, 14'h0000, 14'h0000, 14'h0000);
        add(1, 14'h0000, BP7, 14'h0000, 14'h0000, 14'h0000);
        add(1, 14'h0000, BP7, 14'h0080, 14'h0080, 14'h0000);
        add(1, 14'h0000, BP7, 14'h0000, 14'h0000, 14'h0080);
        add(1, 14'h0000, BP7, 14'h0000, 14'h0000, 14'h0000);

        ResetN      = 1'b1;
        pad_in      = ALL;
        filter_en   = ALL;
        rise_irq_en = '0;
        fall_irq_en = '0;
        irq_clear   = '0;
        #1;
        ResetN = 1'b0;
        repeat (3) step();
        check("reset clean", clean_out, '0);
        check("reset rise", rise_pulse, '0);
        check("reset fall", fall_pulse, '0);
        check("reset pend", irq_pending, '0);
        check("reset irq", {13'b0, irq}, '0);

        ResetN = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            check($sformatf("release e%0d clean", e), clean_out, (e >= 6) ? ALL : 14'h0000);
            check($sformatf("release e%0d rise", e), rise_pulse, (e == 6) ? ALL : 14'h0000);
        end
        pad_in = '0;
        for (int e = 1; e <= 7; e++) begin
            step();
            check($sformatf("drop e%0d clean", e), clean_out, (e >= 6) ? 14'h0000 : ALL);
            check($sformatf("drop e%0d fall", e), fall_pulse, (e == 6) ? ALL : 14'h0000);
        end

        foreach (vecs[k]) begin
            pad_in    = vecs[k].pad;
            filter_en = vecs[k].filt;
            step();
            check($sformatf("vec%0d clean", k), clean_out, vecs[k].clean);
            check($sformatf("vec%0d rise", k), rise_pulse, vecs[k].rise);
            check($sformatf("vec%0d fall", k), fall_pulse, vecs[k].fall);
            check($sformatf("vec%0d pend", k), irq_pending, '0);
            check($sformatf("vec%0d irq", k), {13'b0, irq}, '0);
        end
        filter_en = ALL;

        // Pin 2 mid-count when reset hits, pin 9 already settled high.
        pad_in = 14'h0200;
        repeat (8) step();
        check("pre-reset clean", clean_out, 14'h0200);
        pad_in = 14'h0204;
        repeat (4) step();
        #2;
        ResetN = 1'b0;
        #1;
        check("async reset clean", clean_out, '0);
        step();
        ResetN = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            check($sformatf("rerelease e%0d clean", e), clean_out, (e >= 6) ? 14'h0204 : 14'h0000);
            check($sformatf("rerelease e%0d rise", e), rise_pulse, (e == 6) ? 14'h0204 : 14'h0000);
        end
        pad_in = '0;
        repeat (8) step();
        check("post-reset settle clean", clean_out, '0);

        // Pin 5 edge interrupts: set, set-beats-clear, clear, then falling-edge enable.
        rise_irq_en = 14'h0020;
        pad_in      = 14'h0020;
        for (int e = 1; e <= 7; e++) begin
            step();
            check($sformatf("irq rise e%0d clean", e), clean_out, (e >= 6) ? 14'h0020 : 14'h0000);
            check($sformatf("irq rise e%0d pend", e), irq_pending, (e >= 6) ? P5 : 14'h0000);
            check($sformatf("irq rise e%0d irq", e), {13'b0, irq}, (e == 7) ? I1 : 14'h0000);
        end
        pad_in = '0;
        for (int e = 1; e <= 6; e++) begin
            step();
            check($sformatf("irq low e%0d fall", e), fall_pulse, (e == 6) ? 14'h0020 : 14'h0000);
            check($sformatf("irq low e%0d pend", e), irq_pending, P5);
            check($sformatf("irq low e%0d irq", e), {13'b0, irq}, I1);
        end
        pad_in = 14'h0020;
        repeat (5) step();
        irq_clear = 14'h0020;
        step();
        check("set-vs-clear rise", rise_pulse, 14'h0020);
        check("set-vs-clear pend", irq_pending, P5);
        step();
        check("clear pend", irq_pending, '0);
        check("clear irq lag", {13'b0, irq}, I1);
        irq_clear = '0;
        step();
        check("cleared irq", {13'b0, irq}, '0);

        rise_irq_en = '0;
        fall_irq_en = 14'h0020;
        pad_in      = '0;
        for (int e = 1; e <= 7; e++) begin
            step();
            check($sformatf("irq fall e%0d pend", e), irq_pending, (e >= 6) ? P5 : 14'h0000);
            check($sformatf("irq fall e%0d irq", e), {13'b0, irq}, (e == 7) ? I1 : 14'h0000);
        end
        irq_clear = 14'h0020;
        step();
        check("fall clear pend", irq_pending, '0);
        irq_clear = '0;
        step();
        check("fall cleared irq", {13'b0, irq}, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gpio_input_conditioner.md
Name: gpio_input_conditioner

Overview:
- Per-pin input conditioning between the gpioA pad read net and the SoC's system_gpioA_gpio_read input.
- Synchronises asynchronous pad levels into MainClk and debounces them with a stable-count filter.
- Produces single-cycle rise/fall strobes and an optional edge-interrupt pending register with a combined irq line.
- The SoC sees only clean, glitch-free levels; buttons and switches on the header no longer bounce into software.

Parameters:
- WIDTH, 14: number of pins.
- SYNC_STAGES, 2: synchroniser flop depth; must be ≥2.
- DEBOUNCE_CYCLES, 50000: consecutive differing samples required to accept a new level; must be ≥1. Counter width is clog2(DEBOUNCE_CYCLES+1).

Ports:
- MainClk  input  1  system clock; all logic on its rising edge.
- ResetN  input  1  asynchronous active-low reset.
- pad_in  input  WIDTH  raw pad levels, asynchronous to MainClk.
- filter_en  input  WIDTH  per-pin: 1 = debounce, 0 = bypass (synchronise only).
- clean_out  output  WIDTH  conditioned levels; drive system_gpioA_gpio_read.
- rise_pulse  output  WIDTH  one-cycle strobe on clean_out 0→1.
- fall_pulse  output  WIDTH  one-cycle strobe on clean_out 1→0.
- rise_irq_en  input  WIDTH  per-pin rising-edge interrupt enable.
- fall_irq_en  input  WIDTH  per-pin falling-edge interrupt enable.
- irq_clear  input  WIDTH  write-1-to-clear for pending bits, sampled each cycle.
- irq_pending  output  WIDTH  latched edge events.
- irq  output  1  OR of irq_pending.

Behaviour:
- Reset: ResetN low asynchronously clears all state and outputs.
  - Synchroniser flops, stable registers, counters, clean_out, rise_pulse, fall_pulse, irq_pending and irq all go to 0.
  - Release is synchronous in effect: the first active edge after ResetN rises samples normally.
- Synchroniser: pad_in[i] passes through a SYNC_STAGES flop chain; sync[i] is the last stage. No other logic touches pad_in.
- Debounce, per pin, when filter_en[i]=1:
  - If sync[i]==stable[i], then cnt[i] ← 0.
  - Else if cnt[i]==DEBOUNCE_CYCLES−1, then stable[i] ← sync[i] and cnt[i] ← 0.
  - Else cnt[i] ← cnt[i]+1.
- Any single sample equal to stable restarts the count, so a glitch shorter than DEBOUNCE_CYCLES is fully rejected.
- Latency: a clean pad step reaches clean_out exactly SYNC_STAGES+DEBOUNCE_CYCLES edges after the first edge that samples it.
- Bypass, when filter_en[i]=0: stable[i] ← sync[i] every cycle and cnt[i] ← 0. Latency is SYNC_STAGES+1 edges.
- filter_en change mid-count: counter cleared on the first edge with the new value. No spurious level change.
- clean_out = stable, registered.
- Edge strobes: rise_pulse[i] ← ~stable[i] & stable_next[i], and fall_pulse[i] ← stable[i] & ~stable_next[i].
  - Each strobe is high in exactly the first cycle clean_out shows the new level.
  - It is cleared the following cycle.
- Pins are fully independent; simultaneous events on several pins are all reported in the same cycle.
- No counter wrap is possible: the counter saturates by construction at DEBOUNCE_CYCLES−1, then resets.

Optional Feature:
- Macro: GPIO_EDGE_IRQ_EN.
- Defined:
  - irq_pending[i] is set when (rise_pulse_next[i] & rise_irq_en[i]) | (fall_pulse_next[i] & fall_irq_en[i]), i.e. in the same cycle the strobe asserts.
  - irq_pending[i] is cleared by irq_clear[i]=1.
  - Set and clear in the same cycle: set wins.
  - irq is registered, = |irq_pending, and lags pending by one cycle.
- Undefined:
  - irq_pending and irq are tied 0.
  - rise_irq_en, fall_irq_en and irq_clear are ignored.
  - No pending flops are synthesised.

Test Plan:
- Bench parameters: WIDTH=14, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
- Reset: hold ResetN=0 with pad_in=14'h3FFF → all outputs 0. Release, pad_in steady 1 → clean_out=14'h3FFF exactly 6 edges after release, rise_pulse=14'h3FFF for one cycle.
- Glitch reject: pin 3 from 0, pulse high for 3 cycles then low → clean_out[3] stays 0, no rise_pulse[3]. Pulse high for 4 cycles → clean_out[3]=1 at edge 6, rise_pulse[3] one cycle, later fall after 6 edges of low.
- Bounce: pin 0 toggles 1,0,1,1,0,1,1,1,1 → single rise_pulse[0], asserted 4 edges after the final run begins (plus sync), no fall_pulse[0].
- Bypass: filter_en[7]=0, pad_in[7] 0→1 for 1 cycle → clean_out[7] high for exactly 1 cycle at edge 3, rise then fall strobes.
- IRQ (GPIO_EDGE_IRQ_EN defined): rise_irq_en[5]=1, debounced rise on pin 5 → irq_pending[5]=1, irq=1 next cycle. Assert irq_clear[5] in the same cycle as a second rise → pending stays 1. irq_clear[5] alone → pending 0, irq 0 next cycle.
- Reset mid-count: pin 2 differing for 2 cycles, ResetN pulsed low → counter and clean_out[2] 0, full 6-edge latency restarts after release. Without macro, irq remains 0 throughout.
